// File: rtl/dcache_warmup_loader.sv
// dcache_warmup_loader
// Streams cache-line records (one header, then ROWS data beats) into the L1
// DCache tag and data SRAMs through their RW0 ports while the core is held in
// reset. Each header becomes one masked tag write and each accepted beat one
// masked data-row write, both issued the cycle after the handshake.
// Optional tag readback check after every tag write: DCACHE_WARMUP_READBACK_EN.
module dcache_warmup_loader #(
  parameter  int SETS      = 64,
  parameter  int WAYS      = 4,
  parameter  int TAG_BITS  = 22,
  parameter  int ROW_BYTES = 8,
  parameter  int ROWS      = 8,
  localparam int SET_W     = $clog2(SETS),
  localparam int WAY_W     = $clog2(WAYS),
  localparam int ROW_W     = $clog2(ROWS),
  localparam int BEAT_W    = 8 * ROW_BYTES,
  localparam int LINES_W   = $clog2(SETS * WAYS) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          hdr_valid,
  output logic                          hdr_ready,
  input  logic [SET_W-1:0]              hdr_set,
  input  logic [WAY_W-1:0]              hdr_way,
  input  logic [TAG_BITS-1:0]           hdr_tag,
  input  logic                          hdr_last,
  input  logic                          beat_valid,
  output logic                          beat_ready,
  input  logic [BEAT_W-1:0]             beat_data,
  output logic [SET_W-1:0]              tag_addr,
  output logic                          tag_en,
  output logic                          tag_wmode,
  output logic [WAYS*TAG_BITS-1:0]      tag_wdata,
  output logic [WAYS-1:0]               tag_wmask,
  input  logic [WAYS*TAG_BITS-1:0]      tag_rdata,
  output logic [SET_W+ROW_W-1:0]        data_addr,
  output logic                          data_en,
  output logic                          data_wmode,
  output logic [WAYS*BEAT_W-1:0]        data_wdata,
  output logic [WAYS*ROW_BYTES-1:0]     data_wmask,
  output logic                          busy,
  output logic                          done,
  output logic [LINES_W-1:0]            lines,
  output logic                          error
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_TAG,
`ifdef DCACHE_WARMUP_READBACK_EN
    ST_RDREQ,
    ST_CHK,
`endif
    ST_DATA,
    ST_FIN
  } state_t;

  // Way-0 masks; shifted left by the target way to select one way slice.
  localparam logic [WAYS-1:0]           WAY_MASK0  = {{(WAYS-1){1'b0}}, 1'b1};
  localparam logic [WAYS*ROW_BYTES-1:0] BYTE_MASK0 = {{((WAYS-1)*ROW_BYTES){1'b0}}, {ROW_BYTES{1'b1}}};
  localparam logic [ROW_W-1:0]          ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [LINES_W-1:0]        LINE_MAX   = LINES_W'(SETS * WAYS);

  state_t                      state_r,      state_s;
  logic [SET_W-1:0]            set_r,        set_s;
  logic [WAY_W-1:0]            way_r,        way_s;
  logic [TAG_BITS-1:0]         tag_r,        tag_s;
  logic                        last_r,       last_s;
  logic [ROW_W-1:0]            row_r,        row_s;
  logic                        hdr_ready_r,  hdr_ready_s;
  logic                        beat_ready_r, beat_ready_s;
  logic                        tag_en_r,     tag_en_s;
  logic                        tag_wmode_r,  tag_wmode_s;
  logic [SET_W-1:0]            tag_addr_r,   tag_addr_s;
  logic [WAYS*TAG_BITS-1:0]    tag_wdata_r,  tag_wdata_s;
  logic [WAYS-1:0]             tag_wmask_r,  tag_wmask_s;
  logic                        data_en_r,    data_en_s;
  logic                        data_wmode_r, data_wmode_s;
  logic [SET_W+ROW_W-1:0]      data_addr_r,  data_addr_s;
  logic [WAYS*BEAT_W-1:0]      data_wdata_r, data_wdata_s;
  logic [WAYS*ROW_BYTES-1:0]   data_wmask_r, data_wmask_s;
  logic                        busy_r,       busy_s;
  logic                        done_r,       done_s;
  logic [LINES_W-1:0]          lines_r,      lines_s;
  logic                        error_r,      error_s;

`ifndef DCACHE_WARMUP_READBACK_EN
  // Readback data has no consumer in this build.
  logic unused_tag_rdata_s;
  assign unused_tag_rdata_s = ^tag_rdata;
`endif

  // Next-state and next-output logic; every output is the registered copy.
  always_comb begin
    state_s      = state_r;
    set_s        = set_r;
    way_s        = way_r;
    tag_s        = tag_r;
    last_s       = last_r;
    row_s        = row_r;
    hdr_ready_s  = 1'b0;
    beat_ready_s = 1'b0;
    tag_en_s     = 1'b0;
    tag_wmode_s  = 1'b0;
    tag_addr_s   = tag_addr_r;
    tag_wdata_s  = tag_wdata_r;
    tag_wmask_s  = tag_wmask_r;
    data_en_s    = 1'b0;
    data_wmode_s = 1'b0;
    data_addr_s  = data_addr_r;
    data_wdata_s = data_wdata_r;
    data_wmask_s = data_wmask_r;
    busy_s       = busy_r;
    done_s       = done_r;
    lines_s      = lines_r;
    error_s      = error_r;
    case (state_r)
      ST_IDLE, ST_FIN: begin
        if (start) begin
          state_s     = ST_HDR;
          hdr_ready_s = 1'b1;
          busy_s      = 1'b1;
          done_s      = 1'b0;
          lines_s     = {LINES_W{1'b0}};
          error_s     = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_HDR: begin
        if (hdr_valid && hdr_ready_r) begin
          set_s       = hdr_set;
          way_s       = hdr_way;
          tag_s       = hdr_tag;
          last_s      = hdr_last;
          state_s     = ST_TAG;
          tag_en_s    = 1'b1;
          tag_wmode_s = 1'b1;
          tag_addr_s  = hdr_set;
          tag_wdata_s = {WAYS{hdr_tag}};
          tag_wmask_s = WAY_MASK0 << hdr_way;
        end else begin
          hdr_ready_s = 1'b1;
        end
      end
      ST_TAG: begin
`ifdef DCACHE_WARMUP_READBACK_EN
        // Read the word just written back; its data returns during CHK.
        state_s     = ST_RDREQ;
        tag_en_s    = 1'b1;
        tag_wmode_s = 1'b0;
        tag_addr_s  = set_r;
`else
        state_s      = ST_DATA;
        beat_ready_s = 1'b1;
        row_s        = {ROW_W{1'b0}};
`endif
      end
`ifdef DCACHE_WARMUP_READBACK_EN
      ST_RDREQ: begin
        state_s = ST_CHK;
      end
      ST_CHK: begin
        if (tag_rdata[way_r*TAG_BITS +: TAG_BITS] != tag_r) begin
          error_s = 1'b1;
        end else begin
          error_s = error_r;
        end
        state_s      = ST_DATA;
        beat_ready_s = 1'b1;
        row_s        = {ROW_W{1'b0}};
      end
`endif
      ST_DATA: begin
        if (beat_valid && beat_ready_r) begin
          data_en_s    = 1'b1;
          data_wmode_s = 1'b1;
          data_addr_s  = {set_r, row_r};
          data_wdata_s = {WAYS{beat_data}};
          data_wmask_s = BYTE_MASK0 << (way_r * ROW_BYTES);
          if (row_r == ROW_LAST) begin
            row_s = {ROW_W{1'b0}};
            if (lines_r < LINE_MAX) begin
              lines_s = lines_r + LINES_W'(1);
            end else begin
              lines_s = lines_r;
            end
            if (last_r) begin
              state_s = ST_FIN;
              busy_s  = 1'b0;
              done_s  = 1'b1;
            end else begin
              state_s     = ST_HDR;
              hdr_ready_s = 1'b1;
            end
          end else begin
            row_s        = row_r + ROW_W'(1);
            beat_ready_s = 1'b1;
          end
        end else begin
          beat_ready_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any record in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Captured header, row counter and registered SRAM/status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      set_r        <= {SET_W{1'b0}};
      way_r        <= {WAY_W{1'b0}};
      tag_r        <= {TAG_BITS{1'b0}};
      last_r       <= 1'b0;
      row_r        <= {ROW_W{1'b0}};
      hdr_ready_r  <= 1'b0;
      beat_ready_r <= 1'b0;
      tag_en_r     <= 1'b0;
      tag_wmode_r  <= 1'b0;
      tag_addr_r   <= {SET_W{1'b0}};
      tag_wdata_r  <= {(WAYS*TAG_BITS){1'b0}};
      tag_wmask_r  <= {WAYS{1'b0}};
      data_en_r    <= 1'b0;
      data_wmode_r <= 1'b0;
      data_addr_r  <= {(SET_W+ROW_W){1'b0}};
      data_wdata_r <= {(WAYS*BEAT_W){1'b0}};
      data_wmask_r <= {(WAYS*ROW_BYTES){1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      lines_r      <= {LINES_W{1'b0}};
      error_r      <= 1'b0;
    end else begin
      set_r        <= set_s;
      way_r        <= way_s;
      tag_r        <= tag_s;
      last_r       <= last_s;
      row_r        <= row_s;
      hdr_ready_r  <= hdr_ready_s;
      beat_ready_r <= beat_ready_s;
      tag_en_r     <= tag_en_s;
      tag_wmode_r  <= tag_wmode_s;
      tag_addr_r   <= tag_addr_s;
      tag_wdata_r  <= tag_wdata_s;
      tag_wmask_r  <= tag_wmask_s;
      data_en_r    <= data_en_s;
      data_wmode_r <= data_wmode_s;
      data_addr_r  <= data_addr_s;
      data_wdata_r <= data_wdata_s;
      data_wmask_r <= data_wmask_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
      lines_r      <= lines_s;
      error_r      <= error_s;
    end
  end

  assign hdr_ready  = hdr_ready_r;
  assign beat_ready = beat_ready_r;
  assign tag_addr   = tag_addr_r;
  assign tag_en     = tag_en_r;
  assign tag_wmode  = tag_wmode_r;
  assign tag_wdata  = tag_wdata_r;
  assign tag_wmask  = tag_wmask_r;
  assign data_addr  = data_addr_r;
  assign data_en    = data_en_r;
  assign data_wmode = data_wmode_r;
  assign data_wdata = data_wdata_r;
  assign data_wmask = data_wmask_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign lines      = lines_r;
  assign error      = error_r;

endmodule
